dmem_responder: RTL and testbench

- Memory-side end of the datapath's data-memory access interface.
- Accepts one load/store request at a time from the processor datapath over a valid/ready handshake.
- Models a configurable number of wait states, then returns read data or a write acknowledgement over a valid/ready response channel.
- Range-checks addresses and flags errors. Replaces the zero-latency data memory when the pipeline is extended with stall support.

---
 rtl/dmem_if.sv | 26 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory access bus between the datapath (master) and a memory responder (slave).
// Request and response channels each use a valid/ready handshake.
interface dmem_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data memory responder: one outstanding load/store, range-checked addresses.
// Optional macro DMEM_ALIGN_CHECK_EN also flags odd byte addresses as errors.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BADDR_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cap_write_q, cap_write_d;
  logic [BADDR_W-1:0]  cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   word_idx;
  logic                out_of_range;
  logic                misaligned;
  logic                access_err;

  assign word_idx     = cap_addr_q[ADDR_W:1];
  // Full 15-bit word index compared unsigned, so high addresses never alias low words.
  assign out_of_range = 32'(cap_addr_q[BADDR_W-1:1]) >= DEPTH;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = cap_addr_q[0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = cap_addr_q[0];
  assign misaligned      = 1'b0;
`endif

  assign access_err = out_of_range | misaligned;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_write_d = cap_write_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cap_write_d = bus.req_write;
          cap_addr_d  = bus.req_addr;
          cap_wdata_d = bus.req_wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter at zero means the wait states are spent: this edge commits.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (access_err) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (cap_write_q) begin
            mem_we      = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            rsp_rdata_d = mem_q[word_idx];
          end
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cap_write_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_write_q <= cap_write_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage array; reset wins over a same-edge commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[word_idx] <= cap_wdata_q;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
// Honors DMEM_ALIGN_CHECK_EN in the model when the design is built with it.
module tb_dmem_responder;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int unsigned DEPTH       = 2 ** ADDR_W;

  logic clk;
  logic reset;
  dmem_if bus();

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 16'h0;
  endtask

  // Reference: word index is addr/2; anything beyond the array is an error.
  task automatic model_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                              output logic [15:0] rdata, output logic err);
    int unsigned idx;
    idx = int'(addr) / 2;
    err = (idx >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (addr % 2 == 1) err = 1'b1;
`endif
    rdata = 16'h0;
    if (!err) begin
      if (wr) model_mem[idx] = wdata;
      else    rdata = model_mem[idx];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input int hold);
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic [15:0] held;
    int          lat;
    model_access(wr, addr, wdata, exp_rdata, exp_err);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 16'($urandom);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      check("req_ready_busy", bus.req_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_latency", lat, WAIT_CYCLES + 1);
    if (!bus.rsp_valid) return;
    check("rsp_rdata", bus.rsp_rdata, exp_rdata);
    check("rsp_err", bus.rsp_err, exp_err);
    held = bus.rsp_rdata;
    // While the response is stalled, offer a junk store that must be ignored.
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 16'h0000;
      bus.req_wdata = 16'hFFFF;
      @(posedge clk); #1;
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_rdata", bus.rsp_rdata, held);
      check("hold_err", bus.rsp_err, exp_err);
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("consumed_valid", bus.rsp_valid, 0);
    check("consumed_err", bus.rsp_err, 0);
    check("consumed_req_ready", bus.req_ready, 1);
    check("consumed_rdata_kept", bus.rsp_rdata, held);
  endtask

  initial begin
    logic        wr;
    logic [15:0] addr;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 16'h0;
    bus.rsp_ready = 1'b0;
    do_reset();
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_rdata", bus.rsp_rdata, 0);
    check("reset_rsp_err", bus.rsp_err, 0);

    do_txn(1'b0, 16'h000A, 16'h0000, 0);
    do_txn(1'b1, 16'h0004, 16'hBEEF, 0);
    do_txn(1'b0, 16'h0004, 16'h0000, 0);
    do_txn(1'b0, 16'h0004, 16'h0000, 5);

    do_txn(1'b1, 16'h0000, 16'h0F0F, 0);
    do_txn(1'b1, 16'h0010, 16'h1234, 2);
    do_txn(1'b0, 16'h0010, 16'h0000, 0);
    do_txn(1'b0, 16'h0000, 16'h0000, 0);
    do_txn(1'b1, 16'hFFFE, 16'h7777, 0);
    do_txn(1'b0, 16'h0000, 16'h0000, 0);

    do_txn(1'b1, 16'h0003, 16'h5555, 0);
    do_txn(1'b0, 16'h0002, 16'h0000, 0);
    do_txn(1'b0, 16'h000E, 16'h0000, 1);

    // Reset while the store is still waiting: nothing is committed or returned.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h0006;
    bus.req_wdata = 16'hAAAA;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("midreset_req_ready", bus.req_ready, 1);
    check("midreset_rsp_valid", bus.rsp_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("midreset_no_rsp", bus.rsp_valid, 0);
    end
    bus.rsp_ready = 1'b0;
    do_txn(1'b0, 16'h0006, 16'h0000, 0);

    for (int n = 0; n < 80; n++) begin
      wr   = 1'($urandom);
      addr = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 19));
      do_txn(wr, addr, 16'($urandom), int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < int'(DEPTH); i++) do_txn(1'b0, 16'(2 * i), 16'h0000, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
